// File: rtl/ysyx_23060236_axil_sram.sv
// ysyx_23060236_axil_sram
// AXI4-Lite responder backing the LSU data port with a word-organised array.
// Read and write channels are handled by independent FSMs. Each FSM accepts
// one transaction at a time, with a programmable response latency.
// Addresses are checked for range (DECERR) and alignment (SLVERR).
// Only OKAY writes touch the array.
module ysyx_23060236_axil_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RD_LAT      = 1,
    parameter int          WR_LAT      = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    input  logic [2:0]  arsize,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    input  logic [2:0]  awsize,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
    localparam int          RCNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int          WCNT_W    = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
    localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(RD_LAT - 1);
    localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(WR_LAT - 1);
    localparam logic [RCNT_W-1:0] RCNT_ZERO = {RCNT_W{1'b0}};
    localparam logic [WCNT_W-1:0] WCNT_ZERO = {WCNT_W{1'b0}};
    localparam logic [RCNT_W-1:0] RCNT_ONE  = {{(RCNT_W-1){1'b0}}, 1'b1};
    localparam logic [WCNT_W-1:0] WCNT_ONE  = {{(WCNT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rstate_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wstate_t;

    // Range check first (DECERR), then natural alignment for the access size (SLVERR).
    function automatic logic [1:0] addr_check(input logic [31:0] addr, input logic [2:0] size);
        logic [31:0] off;
        logic [1:0]  res;
        off = addr - ADDR_BASE;
        if ((addr < ADDR_BASE) || (off >= SPAN)) begin
            res = RESP_DECERR;
        end else if ((size == 3'd1) && (addr[0] != 1'b0)) begin
            res = RESP_SLVERR;
        end else if ((size == 3'd2) && (addr[1:0] != 2'b00)) begin
            res = RESP_SLVERR;
        end else if (size >= 3'd3) begin
            res = RESP_SLVERR;
        end else begin
            res = RESP_OKAY;
        end
        return res;
    endfunction

    // Word index relative to the base; only meaningful when the range check passed.
    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_BASE;
        return off[IDX_W+1:2];
    endfunction

    logic [31:0] mem_r [DEPTH_WORDS];

    // ---------------- read path ----------------
    rstate_t           rstate_r, rstate_nx;
    logic [RCNT_W-1:0] rcnt_r;
    logic [IDX_W-1:0]  ridx_r;
    logic [1:0]        rres_r;
    logic [31:0]       rdata_r;
    logic [1:0]        rresp_r;
    logic              rvalid_r;
    logic              arready_r;
    logic              ar_hs_s;
    logic              r_hs_s;
    logic              rsample_s;

    assign ar_hs_s = arvalid & arready_r;
    assign r_hs_s  = rvalid_r & rready;

    // Read next-state: every access passes through R_WAIT so that rvalid rises RD_LAT edges after AR.
    always_comb begin
        rstate_nx = rstate_r;
        rsample_s = 1'b0;
        case (rstate_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rstate_nx = R_WAIT;
                end else begin
                    rstate_nx = R_IDLE;
                end
            end
            R_WAIT: begin
                if (rcnt_r == RCNT_ZERO) begin
                    rstate_nx = R_RESP;
                    rsample_s = 1'b1;
                end else begin
                    rstate_nx = R_WAIT;
                end
            end
            R_RESP: begin
                if (r_hs_s) begin
                    rstate_nx = R_IDLE;
                end else begin
                    rstate_nx = R_RESP;
                end
            end
            default: begin
                rstate_nx = R_IDLE;
            end
        endcase
    end

    // Read state, latched request, countdown and registered R-channel outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rstate_r  <= R_IDLE;
            rcnt_r    <= RCNT_ZERO;
            ridx_r    <= {IDX_W{1'b0}};
            rres_r    <= RESP_OKAY;
            rdata_r   <= 32'h0000_0000;
            rresp_r   <= RESP_OKAY;
            rvalid_r  <= 1'b0;
            arready_r <= 1'b1;
        end else begin
            rstate_r  <= rstate_nx;
            arready_r <= (rstate_nx == R_IDLE);
            rvalid_r  <= (rstate_nx == R_RESP);
            if (ar_hs_s) begin
                ridx_r <= word_idx(araddr);
                rres_r <= addr_check(araddr, arsize);
                rcnt_r <= RCNT_LOAD;
            end else if ((rstate_r == R_WAIT) && (rcnt_r != RCNT_ZERO)) begin
                rcnt_r <= rcnt_r - RCNT_ONE;
            end
            if (rsample_s) begin
                rresp_r <= rres_r;
                rdata_r <= (rres_r == RESP_OKAY) ? mem_r[ridx_r] : 32'h0000_0000;
            end
        end
    end

    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rdata   = rdata_r;
    assign rresp   = rresp_r;

    // ---------------- write path ----------------
    wstate_t           wstate_r, wstate_nx;
    logic [WCNT_W-1:0] wcnt_r;
    logic [IDX_W-1:0]  widx_r;
    logic [1:0]        wres_r;
    logic [31:0]       wdata_r;
    logic [3:0]        wstrb_r;
    logic              have_aw_r, have_aw_nx;
    logic              have_w_r, have_w_nx;
    logic [1:0]        bresp_r;
    logic              bvalid_r;
    logic              awready_r;
    logic              wready_r;
    logic              aw_hs_s;
    logic              w_hs_s;
    logic              b_hs_s;
    logic              wdone_s;
    logic              wcommit_s;

    assign aw_hs_s = awvalid & awready_r;
    assign w_hs_s  = wvalid & wready_r;
    assign b_hs_s  = bvalid_r & bready;

    // Write next-state: the countdown starts on the edge that completes the later of AW/W.
    always_comb begin
        wstate_nx  = wstate_r;
        have_aw_nx = have_aw_r | aw_hs_s;
        have_w_nx  = have_w_r | w_hs_s;
        wdone_s    = 1'b0;
        wcommit_s  = 1'b0;
        case (wstate_r)
            W_IDLE: begin
                if (have_aw_nx && have_w_nx) begin
                    wstate_nx = W_WAIT;
                end else begin
                    wstate_nx = W_IDLE;
                end
            end
            W_WAIT: begin
                if (wcnt_r == WCNT_ZERO) begin
                    wstate_nx = W_RESP;
                    wdone_s   = 1'b1;
                    wcommit_s = (wres_r == RESP_OKAY);
                end else begin
                    wstate_nx = W_WAIT;
                end
            end
            W_RESP: begin
                if (b_hs_s) begin
                    wstate_nx  = W_IDLE;
                    have_aw_nx = 1'b0;
                    have_w_nx  = 1'b0;
                end else begin
                    wstate_nx = W_RESP;
                end
            end
            default: begin
                wstate_nx  = W_IDLE;
                have_aw_nx = 1'b0;
                have_w_nx  = 1'b0;
            end
        endcase
    end

    // Write state, per-channel capture flags, countdown and registered AW/W/B outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wstate_r  <= W_IDLE;
            wcnt_r    <= WCNT_ZERO;
            widx_r    <= {IDX_W{1'b0}};
            wres_r    <= RESP_OKAY;
            wdata_r   <= 32'h0000_0000;
            wstrb_r   <= 4'b0000;
            have_aw_r <= 1'b0;
            have_w_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
        end else begin
            wstate_r  <= wstate_nx;
            have_aw_r <= have_aw_nx;
            have_w_r  <= have_w_nx;
            awready_r <= (wstate_nx == W_IDLE) && !have_aw_nx;
            wready_r  <= (wstate_nx == W_IDLE) && !have_w_nx;
            bvalid_r  <= (wstate_nx == W_RESP);
            if (aw_hs_s) begin
                widx_r <= word_idx(awaddr);
                wres_r <= addr_check(awaddr, awsize);
            end
            if (w_hs_s) begin
                wdata_r <= wdata;
                wstrb_r <= wstrb;
            end
            if ((wstate_r == W_IDLE) && (wstate_nx == W_WAIT)) begin
                wcnt_r <= WCNT_LOAD;
            end else if ((wstate_r == W_WAIT) && (wcnt_r != WCNT_ZERO)) begin
                wcnt_r <= wcnt_r - WCNT_ONE;
            end
            if (wdone_s) begin
                bresp_r <= wres_r;
            end
        end
    end

    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;

    // Byte-lane commit into the array; a read sampling the same word on this edge sees old data.
    always_ff @(posedge clock) begin
        if (wcommit_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_r[b]) begin
                    mem_r[widx_r][8*b +: 8] <= wdata_r[8*b +: 8];
                end
            end
        end
    end

endmodule
